// File: rtl/down_counter_if.sv
// Load/count bus for down_counter: parallel-load request and data in, counter
// value and status flags out.
interface down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load_en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             underflow;

    modport master (
        output load_en,
        output d,
        input  q,
        input  zero,
        input  underflow
    );

    modport slave (
        input  load_en,
        input  d,
        output q,
        output zero,
        output underflow
    );
endinterface

// File: rtl/down_counter.sv
// Free-running down counter with parallel load and a one-cycle underflow pulse.
// Define DOWN_COUNTER_SATURATE_EN to hold at zero instead of wrapping to all-ones.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    down_counter_if.slave bus
);
    logic [WIDTH-1:0] q_r;
    logic             uf_r;

`ifdef DOWN_COUNTER_SATURATE_EN
    // Set once the saturating step has fired, so the pulse is not repeated
    // while the counter sits at zero.
    logic held_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= '0;
            uf_r   <= 1'b0;
            held_r <= 1'b0;
        end else if (bus.load_en) begin
            q_r    <= bus.d;
            uf_r   <= 1'b0;
            held_r <= 1'b0;
        end else if (q_r == '0) begin
            q_r    <= '0;
            uf_r   <= ~held_r;
            held_r <= 1'b1;
        end else begin
            q_r    <= q_r - WIDTH'(1);
            uf_r   <= 1'b0;
            held_r <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r  <= '0;
            uf_r <= 1'b0;
        end else if (bus.load_en) begin
            q_r  <= bus.d;
            uf_r <= 1'b0;
        end else if (q_r == '0) begin
            q_r  <= '1;
            uf_r <= 1'b1;
        end else begin
            q_r  <= q_r - WIDTH'(1);
            uf_r <= 1'b0;
        end
    end
`endif

    assign bus.q         = q_r;
    assign bus.zero      = (q_r == '0);
    assign bus.underflow = uf_r;
endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: WIDTH=4 main instance plus a WIDTH=8 instance.
module tb_down_counter;
    typedef struct packed {
        logic [3:0] q;
        logic       zero;
        logic       uf;
    } exp4_t;

    typedef struct packed {
        logic [7:0] q;
        logic       zero;
        logic       uf;
    } exp8_t;

    logic clk;
    logic reset;
    logic reset8;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp4_t sb[$];
    exp8_t sb8[$];

    // reference state for the 4-bit instance
    logic [3:0] m_q;
    logic       m_uf;
    logic       m_held;

    down_counter_if #(.WIDTH(4)) bus4 ();
    down_counter_if #(.WIDTH(8)) bus8 ();

    down_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset),  .bus(bus4.slave));
    down_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset8), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one cycle of stimulus and push the result expected after the next edge
    task automatic drv(input logic r, input logic l, input logic [3:0] dv);
        exp4_t e;
        reset        = r;
        bus4.load_en = l;
        bus4.d       = dv;
        if (r) begin
            m_q = 4'h0; m_uf = 1'b0; m_held = 1'b0;
        end else if (l) begin
            m_q = dv; m_uf = 1'b0; m_held = 1'b0;
        end else if (m_q == 4'h0) begin
`ifdef DOWN_COUNTER_SATURATE_EN
            m_uf = ~m_held; m_held = 1'b1;
`else
            m_q = 4'hF; m_uf = 1'b1;
`endif
        end else begin
            m_q = m_q - 4'h1; m_uf = 1'b0; m_held = 1'b0;
        end
        e.q = m_q; e.zero = (m_q == 4'h0); e.uf = m_uf;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        exp4_t e;
        drv(1'b1, 1'b0, 4'h0);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf ||
            bus4.q !== 4'h0 || bus4.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                     bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
        end
    endtask

    task automatic test_wrap;
        exp4_t e;
        logic [3:0] lit_q[2];
        logic       lit_uf[2];
        lit_q[0] = 4'hF; lit_uf[0] = 1'b1;
        lit_q[1] = 4'hE; lit_uf[1] = 1'b0;
`ifdef DOWN_COUNTER_SATURATE_EN
        lit_q[0] = 4'h0; lit_q[1] = 4'h0;
`endif
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, 1'b0, 4'h0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf ||
                bus4.q !== lit_q[i] || bus4.underflow !== lit_uf[i]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                         i, bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
            end
        end
    endtask

    task automatic test_load_count;
        exp4_t e;
        logic [3:0] lit[4];
        lit[0] = 4'b1011; lit[1] = 4'b1010; lit[2] = 4'b1001; lit[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drv(1'b0, 1'b1, 4'b1011);
            else        drv(1'b0, 1'b0, 4'h3);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf ||
                bus4.q !== lit[i]) begin
                n_fail++;
                $display("FAIL load_count[%0d]: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                         i, bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
            end
        end
    endtask

    task automatic test_reset_load;
        exp4_t e;
        drv(1'b1, 1'b1, 4'b0110);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf ||
            bus4.q !== 4'h0 || bus4.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                     bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
        end
    endtask

    // load 1, step through zero, then load-held and load-zero corner cases
    task automatic test_boundary;
        exp4_t e;
        logic       r_l[9];
        logic [3:0] r_d[9];
        r_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        r_d = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0};
        for (int i = 0; i < 9; i++) begin
            drv(1'b0, r_l[i], r_d[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf) begin
                n_fail++;
                $display("FAIL boundary[%0d]: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                         i, bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp4_t e;
        for (int i = 0; i < 7; i++) begin
            if (i == 0)     drv(1'b0, 1'b1, 4'b1000);
            else if (i < 4) drv(1'b1, 1'b0, 4'h0);
            else            drv(1'b0, 1'b0, 4'h0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                         i, bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
            end
        end
    endtask

    task automatic test_x_data;
        exp4_t e;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drv(1'b0, 1'b1, 4'hC);
            else        drv(1'b0, 1'b0, 4'bxzx1);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf) begin
                n_fail++;
                $display("FAIL x_data[%0d]: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                         i, bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
            end
        end
    endtask

    task automatic test_reset_no_edge;
        exp4_t e;
        drv(1'b0, 1'b1, 4'h5);
        @(posedge clk); #1;
        e = sb.pop_front();
        drv(1'b1, 1'b0, 4'h0);
        #3;
        n_tests++;
        if (bus4.q !== e.q || bus4.q !== 4'h5) begin
            n_fail++;
            $display("FAIL reset_no_edge: got q=%h before edge, want q=%h", bus4.q, e.q);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_tests++;
        if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf) begin
            n_fail++;
            $display("FAIL reset_edge: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                     bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
        end
    endtask

    task automatic test_random;
        exp4_t e;
        for (int i = 0; i < 300; i++) begin
            drv(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if (bus4.q !== e.q || bus4.zero !== e.zero || bus4.underflow !== e.uf) begin
                n_fail++;
                $display("FAIL random[%0d]: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                         i, bus4.q, bus4.zero, bus4.underflow, e.q, e.zero, e.uf);
            end
        end
    endtask

    task automatic test_width8;
        exp8_t e;
        logic       r_r[4];
        logic       r_l[4];
        r_r = '{1'b1, 1'b0, 1'b0, 1'b0};
        r_l = '{1'b0, 1'b1, 1'b0, 1'b0};
        sb8.push_back('{8'h00, 1'b1, 1'b0});
        sb8.push_back('{8'h00, 1'b1, 1'b0});
`ifdef DOWN_COUNTER_SATURATE_EN
        sb8.push_back('{8'h00, 1'b1, 1'b1});
        sb8.push_back('{8'h00, 1'b1, 1'b0});
`else
        sb8.push_back('{8'hFF, 1'b0, 1'b1});
        sb8.push_back('{8'hFE, 1'b0, 1'b0});
`endif
        for (int i = 0; i < 4; i++) begin
            reset8       = r_r[i];
            bus8.load_en = r_l[i];
            bus8.d       = 8'h00;
            @(posedge clk); #1;
            e = sb8.pop_front();
            n_tests++;
            if (bus8.q !== e.q || bus8.zero !== e.zero || bus8.underflow !== e.uf) begin
                n_fail++;
                $display("FAIL width8[%0d]: got q=%h zero=%b uf=%b, want q=%h zero=%b uf=%b",
                         i, bus8.q, bus8.zero, bus8.underflow, e.q, e.zero, e.uf);
            end
        end
    endtask

    initial begin
        reset = 1'b0; reset8 = 1'b1;
        bus4.load_en = 1'b0; bus4.d = 4'h0;
        bus8.load_en = 1'b0; bus8.d = 8'h00;
        m_q = 4'h0; m_uf = 1'b0; m_held = 1'b0;
        #1;
        test_reset;
        test_wrap;
        test_load_count;
        test_reset_load;
        test_boundary;
        test_reset_mid;
        test_x_data;
        test_reset_no_edge;
        test_random;
        test_width8;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and load-data width in bits (legal 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 load_en  input  1  parallel-load request, sampled on rising clk edge.
REQ-005 d  input  WIDTH  parallel-load value, sampled when load_en=1.
REQ-006 q  output  WIDTH  registered counter value.
REQ-007 zero  output  1  combinational flag, 1 when q equals 0.
REQ-008 underflow  output  1  registered one-cycle pulse marking a count step taken from q=0.

Function
REQ-009 Per rising edge, priority is reset > load_en > count; exactly one action occurs.
REQ-010 reset=1: q <= 0 and underflow <= 0, regardless of load_en and d.
REQ-011 reset=0, load_en=1: q <= d on the same edge (q shows d one cycle after load_en is sampled); underflow <= 0.
REQ-012 reset=0, load_en=0: q <= q - 1 modulo 2^WIDTH every cycle; no count-enable gating.
REQ-013 Count step from q=0 (macro absent): q <= 2^WIDTH-1 (4'b1111 for WIDTH=4) and underflow <= 1 for that one cycle.
REQ-014 Any count step from q!=0: underflow <= 0.
REQ-015 load_en held high for several cycles: q re-loads d each cycle and does not count.
REQ-016 load_en=1 with d=0: q <= 0, zero=1 next cycle, no underflow pulse.
REQ-017 X/Z on d while load_en=0 is ignored and does not affect q.
REQ-018 No combinational path from any input to q or underflow; zero depends only on q.

Reset
REQ-019 Reset is synchronous only; with reset=1 and no clock edge, q holds its value.
REQ-020 After the first reset edge: q=0, zero=1, underflow=0.
REQ-021 Reset asserted mid-count or together with load_en forces q=0 on that edge; counting resumes from 0 on the first edge after reset deasserts (next value 2^WIDTH-1 with underflow pulse, unless saturating per REQ-023).
REQ-022 Power-up value of q before the first reset edge is undefined; no initial blocks are relied on.

Configuration
REQ-023 Macro DOWN_COUNTER_SATURATE_EN defined: a count step at q=0 keeps q=0 (no wrap) and asserts underflow for one cycle; underflow then stays 0 while q remains held at 0.
REQ-024 Macro DOWN_COUNTER_SATURATE_EN absent: wrap-around behaviour of REQ-013; all other requirements identical in both builds.

Verification
REQ-025 reset=1 for 1 edge, then reset=0, load_en=0 -> q=0, zero=1; next edge q=4'b1111 with underflow=1 for one cycle; following edge q=4'b1110, underflow=0.
REQ-026 load_en=1, d=4'b1011 for one edge, then load_en=0 for 3 edges -> q sequence 1011, 1010, 1001, 1000.
REQ-027 reset=1 and load_en=1 with d=4'b0110 on the same edge -> q=0, underflow=0.
REQ-028 Load d=4'b0001, count 2 edges -> q=0000 (zero=1, underflow=0), then q=1111 with underflow=1; with DOWN_COUNTER_SATURATE_EN, second step gives q=0000 with underflow=1, and a third step gives q=0000 with underflow=0.
REQ-029 reset=1 asserted while counting from q=4'b1000, held 3 edges -> q=0 on every edge; after release, counting restarts from 0.
REQ-030 WIDTH=8: load d=8'h00, count one edge -> q=8'hFF, underflow=1.
